// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and TX-core-side signals for uart_tx_arbiter.
// req_lock is present only when UART_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ack;
`ifdef UART_ARB_LOCK_EN
  logic [NUM_REQ-1:0]        req_lock;
`endif
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;

`ifdef UART_ARB_LOCK_EN
  // Arbiter side.
  modport master (
    input  req, req_data, req_lock, tx_ready,
    output req_ack, tx_data, tx_valid, grant_id, busy
  );
  // Producers plus TX core side.
  modport slave (
    output req, req_data, req_lock, tx_ready,
    input  req_ack, tx_data, tx_valid, grant_id, busy
  );
`else
  modport master (
    input  req, req_data, tx_ready,
    output req_ack, tx_data, tx_valid, grant_id, busy
  );
  modport slave (
    output req, req_data, tx_ready,
    input  req_ack, tx_data, tx_valid, grant_id, busy
  );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core between NUM_REQ byte producers.
// Optional UART_ARB_LOCK_EN adds req_lock to keep priority on a multi-byte frame.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk_in,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = 16;
  localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0]  tx_data_q;
  logic               tx_valid_q;
  logic [NUM_REQ-1:0] req_ack_q;
  logic [ID_W-1:0]    grant_q;
  logic [ID_W-1:0]    prio;
  logic [GAP_W-1:0]   gap_cnt;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 found;
  logic [ID_W-1:0]      offset;
  logic [ID_W:0]        win_sum;
  logic [ID_W-1:0]      winner;
  logic                 handoff;
  logic [ID_W-1:0]      grant_inc;
  logic [ID_W-1:0]      next_prio;

`ifdef UART_ARB_LOCK_EN
  logic lock_q;
`endif

  // Rotate requests so that bit 0 is the current priority holder; the first
  // set bit of the rotated vector is the winner's distance from prio.
  assign req_dbl = {bus.req, bus.req};
  assign req_rot = req_dbl[prio +: NUM_REQ];

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found  = 1'b1;
        offset = ID_W'(i);
      end
    end
  end

  always_comb begin
    win_sum = {1'b0, prio} + {1'b0, offset};
    if (win_sum >= NUM_REQ_W) begin
      winner = ID_W'(win_sum - NUM_REQ_W);
    end else begin
      winner = ID_W'(win_sum);
    end
  end

  assign handoff   = (state == SEND) && tx_valid_q && bus.tx_ready;
  assign grant_inc = (grant_q == LAST_ID) ? '0 : grant_q + ID_W'(1);

`ifdef UART_ARB_LOCK_EN
  assign next_prio = lock_q ? grant_q : grant_inc;
`else
  assign next_prio = grant_inc;
`endif

  // State register and datapath.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      req_ack_q  <= '0;
      grant_q    <= '0;
      prio       <= '0;
      gap_cnt    <= '0;
`ifdef UART_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      req_ack_q <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            tx_data_q  <= bus.req_data[winner*DATA_W +: DATA_W];
            grant_q    <= winner;
            req_ack_q  <= NUM_REQ'(1) << winner;
            tx_valid_q <= 1'b1;
`ifdef UART_ARB_LOCK_EN
            lock_q     <= bus.req_lock[winner];
`endif
          end
        end
        SEND: begin
          if (handoff) begin
            tx_valid_q <= 1'b0;
            prio       <= next_prio;
            gap_cnt    <= GAP_LOAD;
          end
        end
        GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (handoff) begin
          state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.busy     = (state != IDLE);
    bus.tx_data  = tx_data_q;
    bus.tx_valid = tx_valid_q;
    bus.req_ack  = req_ack_q;
    bus.grant_id = grant_q;
  end
endmodule
